uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 54, giving clk cycles per oversample tick (range 1..65535).
REQ-002 The block SHALL have parameter OVS, default 16, giving oversample ticks per bit (even, 8..32).
REQ-003 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame (5..9).
REQ-004 The block SHALL have parameter PARITY, default 0, selecting parity: 0 none, 1 odd, 2 even.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, giving stop bits per frame (1 or 2).
REQ-006 The block SHALL have port clk, input, 1 bit, system clock.
REQ-007 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port rx, input, 1 bit, asynchronous serial line, idle high.
REQ-009 The block SHALL have port rx_data, output, DATA_BITS bits, received word, LSB first on line.
REQ-010 The block SHALL have port rx_valid, output, 1 bit, rx_data and flags valid.
REQ-011 The block SHALL have port rx_ack, input, 1 bit, consumer accepts the word.
REQ-012 The block SHALL have port frame_err, output, 1 bit, stop bit sampled low; qualified by rx_valid.
REQ-013 The block SHALL have port parity_err, output, 1 bit, parity mismatch; qualified by rx_valid.
REQ-014 The block SHALL have port overrun, output, 1 bit, sticky flag set when a frame is lost.
REQ-015 The block SHALL have port busy, output, 1 bit, high when the FSM is not IDLE.

Function
REQ-016 rx SHALL pass a 2-flop synchronizer with reset value 1; all logic SHALL use the synchronized value only.
REQ-017 The tick counter SHALL count 0..CLK_DIV-1 and emit a one-clk tick at wrap; it SHALL reset to 0 on start detection so bit timing aligns to the falling edge.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY=0.
REQ-019 In IDLE, a 1->0 transition of synchronized rx SHALL enter START and clear the tick and sample counters.
REQ-020 Each bit SHALL be decided by 2-of-3 majority of samples at ticks OVS/2-1, OVS/2 and OVS/2+1 of the bit period.
REQ-021 If the START bit decides 1 (false start), the FSM SHALL return to IDLE with no output and no flag change.
REQ-022 DATA SHALL shift DATA_BITS decided bits LSB first, then advance after OVS ticks per bit.
REQ-023 PARITY SHALL compare the decided bit with XOR of data (even) or its inverse (odd); mismatch sets the pending parity_err.
REQ-024 STOP SHALL decide STOP_BITS bits; any stop bit decided 0 SHALL set the pending frame_err.
REQ-025 After the last stop bit decision at tick OVS/2+1, the FSM SHALL return to IDLE immediately, so back-to-back frames are accepted.
REQ-026 At frame end with rx_valid low, rx_data, frame_err and parity_err SHALL load and rx_valid SHALL rise one clk later.
REQ-027 rx_valid SHALL stay high, with data and flags stable, until a clk where rx_ack is high; it SHALL then drop on the next clk.
REQ-028 If a frame ends while rx_valid is high and rx_ack is low, the new frame SHALL be discarded and overrun set; held data SHALL be unchanged.
REQ-029 If rx_ack and frame end coincide, the ack SHALL be honoured and the new frame loaded, with rx_valid staying high and no overrun.
REQ-030 overrun SHALL clear only on a clk where rx_ack is high and rx_valid is high.
REQ-031 A frame with frame_err SHALL still be delivered; recovery SHALL require rx high before the next start detection (break held low produces one frame only).

Reset
REQ-032 On rst low, the FSM SHALL go to IDLE, counters to 0, synchronizer to 1, rx_data to 0, and rx_valid, frame_err, parity_err, overrun and busy to 0.
REQ-033 Reset mid-frame SHALL abort the frame with no output; after release, a start SHALL be detected only after rx is seen high.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the PARITY constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2).
REQ-035 The tick generator SHALL be one sub-module, uart_tick_gen, with ports clk, rst, sync_clr and tick.

Verification
REQ-036 Bench SHALL use CLK_DIV=4, OVS=16, 8N1: frame 0xA5 -> rx_valid with rx_data=0xA5, both error flags 0.
REQ-037 8E1, byte 0x03 sent with parity 1 -> parity_err=1, rx_data=0x03; sent with parity 0 -> parity_err=0.
REQ-038 A 6-tick low glitch on idle line -> no rx_valid, busy returns to 0 within one bit time.
REQ-039 Two back-to-back frames 0x11 and 0x22 with rx_ack held low -> rx_data=0x11 retained and overrun=1; ack -> overrun=0.
REQ-040 Stop bit driven 0 on 0x7E -> rx_valid with frame_err=1; a following 0x55 after idle is received clean.
REQ-041 rst asserted mid-DATA of 0xFF -> all outputs 0, no rx_valid after release, next frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver.
// FSM state encoding and parity mode constants.
package uart_rx_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-clk tick every CLK_DIV clks; sync_clr restarts the period.
// Latency: first tick CLK_DIV clks after sync_clr. No backpressure.
module uart_tick_gen #(
    parameter int CLK_DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_clr,
    output logic tick
);

    localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (sync_clr || (cnt_q == DIV_MAX)) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == DIV_MAX);

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with majority-vote bit decision, parity/stop checking and a one-word holding register.
// Latency: word presented one clk after the last stop bit decision. Backpressure: rx_valid holds until rx_ack; frames ending while held are dropped and flag overrun.
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int CLK_DIV   = 54,
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [4:0] SMP_A      = 5'(OVS/2 - 1);
    localparam logic [4:0] SMP_B      = 5'(OVS/2);
    localparam logic [4:0] SMP_C      = 5'(OVS/2 + 1);
    localparam logic [4:0] SMP_LAST   = 5'(OVS - 1);
    localparam logic [3:0] DBITS_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] SBITS_LAST = 4'(STOP_BITS - 1);

    logic rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
    logic [1:0] settle_q, settle_d;
    state_t state_q, state_d;
    logic [4:0] samp_q, samp_d;
    logic [3:0] bit_q, bit_d;
    logic s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic fe_pend_q, fe_pend_d, pe_pend_q, pe_pend_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
    logic parity_err_q, parity_err_d, overrun_q, overrun_d;

    logic tick, start_det, edge_det, maj, decide, bit_end, frame_done, fe_now, exp_par;

    uart_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .sync_clr (start_det),
        .tick     (tick)
    );

    // Edge detection waits until the synchronizer and prev flop hold real line
    // samples, so a line held low through reset cannot fake a start bit.
    assign edge_det = (settle_q == 2'd3) && rx_prev_q && !rx_sync_q;
    assign maj      = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);
    assign decide   = tick && (samp_q == SMP_C);
    assign bit_end  = tick && (samp_q == SMP_LAST);
    assign exp_par  = (PARITY == PAR_ODD) ? ~(^shift_q) : ^shift_q;

    always_comb begin
        rx_meta_d  = rx;
        rx_sync_d  = rx_meta_q;
        rx_prev_d  = rx_sync_q;
        settle_d   = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        state_d    = state_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        shift_d    = shift_q;
        fe_pend_d  = fe_pend_q;
        pe_pend_d  = pe_pend_q;
        fe_now     = fe_pend_q;
        start_det  = 1'b0;
        frame_done = 1'b0;

        if (state_q != ST_IDLE && tick) begin
            samp_d = (samp_q == SMP_LAST) ? 5'd0 : samp_q + 5'd1;
            if (samp_q == SMP_A) s0_d = rx_sync_q;
            if (samp_q == SMP_B) s1_d = rx_sync_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (edge_det) begin
                    state_d   = ST_START;
                    samp_d    = '0;
                    bit_d     = '0;
                    fe_pend_d = 1'b0;
                    pe_pend_d = 1'b0;
                    start_det = 1'b1;
                end
            end
            ST_START: begin
                if (decide && maj) state_d = ST_IDLE;
                else if (bit_end)  state_d = ST_DATA;
            end
            ST_DATA: begin
                if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == DBITS_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) pe_pend_d = (maj != exp_par);
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (decide) begin
                    fe_now    = fe_pend_q | ~maj;
                    fe_pend_d = fe_now;
                    if (bit_q == SBITS_LAST) begin
                        state_d    = ST_IDLE;
                        frame_done = 1'b1;
                    end
                end else if (bit_end) begin
                    bit_d = bit_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        if (rx_valid_q && rx_ack) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
        // An ack in the same clk frees the holding register for the new word.
        if (frame_done) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_d    = shift_q;
                frame_err_d  = fe_now;
                parity_err_d = pe_pend_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            settle_q     <= '0;
            state_q      <= ST_IDLE;
            samp_q       <= '0;
            bit_q        <= '0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            shift_q      <= '0;
            fe_pend_q    <= 1'b0;
            pe_pend_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            settle_q     <= settle_d;
            state_q      <= state_d;
            samp_q       <= samp_d;
            bit_q        <= bit_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            shift_q      <= shift_d;
            fe_pend_q    <= fe_pend_d;
            pe_pend_q    <= pe_pend_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and an 8E1 instance, CLK_DIV=4, OVS=16.
module tb_uart_rx_cfg;

    localparam int BIT_CLKS = 64;

    logic clk = 1'b0;
    logic rst;
    logic rx_n, rx_e, ack_n, ack_e;
    logic [7:0] data_n, data_e;
    logic vld_n, vld_e, fe_n, fe_e, pe_n, pe_e, ovr_n, ovr_e, busy_n, busy_e;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_DIV(4), .OVS(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .rst(rst), .rx(rx_n), .rx_data(data_n), .rx_valid(vld_n), .rx_ack(ack_n),
        .frame_err(fe_n), .parity_err(pe_n), .overrun(ovr_n), .busy(busy_n)
    );

    uart_rx_cfg #(.CLK_DIV(4), .OVS(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
        .clk(clk), .rst(rst), .rx(rx_e), .rx_data(data_e), .rx_valid(vld_e), .rx_ack(ack_e),
        .frame_err(fe_e), .parity_err(pe_e), .overrun(ovr_e), .busy(busy_e)
    );

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_e = v;
        else     rx_n = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input bit has_par,
                              input logic par, input logic stop_v);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
        if (has_par) drive_bit(sel, par);
        drive_bit(sel, stop_v);
    endtask

    task automatic pulse_ack(input bit sel);
        if (sel) ack_e = 1'b1; else ack_n = 1'b1;
        @(negedge clk);
        if (sel) ack_e = 1'b0; else ack_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        checks += 7;
        if (vld_n !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b expected 0", vld_n); end
        if (data_n !== 8'h00)   begin errors++; $display("FAIL reset_data: got %h expected 00", data_n); end
        if (fe_n !== 1'b0)      begin errors++; $display("FAIL reset_frame_err: got %b expected 0", fe_n); end
        if (pe_n !== 1'b0)      begin errors++; $display("FAIL reset_parity_err: got %b expected 0", pe_n); end
        if (ovr_n !== 1'b0)     begin errors++; $display("FAIL reset_overrun: got %b expected 0", ovr_n); end
        if (busy_n !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_n); end
        if (vld_e !== 1'b0)     begin errors++; $display("FAIL reset_valid_e: got %b expected 0", vld_e); end
    endtask

    task automatic test_basic;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        checks += 4;
        if (vld_n !== 1'b1)   begin errors++; $display("FAIL basic_valid: got %b expected 1", vld_n); end
        if (data_n !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", data_n); end
        if (fe_n !== 1'b0)    begin errors++; $display("FAIL basic_frame_err: got %b expected 0", fe_n); end
        if (pe_n !== 1'b0)    begin errors++; $display("FAIL basic_parity_err: got %b expected 0", pe_n); end
        pulse_ack(1'b0);
        checks++;
        if (vld_n !== 1'b0)   begin errors++; $display("FAIL basic_ack_drop: got %b expected 0", vld_n); end
    endtask

    task automatic test_parity;
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        checks += 3;
        if (vld_e !== 1'b1)   begin errors++; $display("FAIL par_bad_valid: got %b expected 1", vld_e); end
        if (data_e !== 8'h03) begin errors++; $display("FAIL par_bad_data: got %h expected 03", data_e); end
        if (pe_e !== 1'b1)    begin errors++; $display("FAIL par_bad_flag: got %b expected 1", pe_e); end
        pulse_ack(1'b1);
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        checks += 3;
        if (vld_e !== 1'b1)   begin errors++; $display("FAIL par_ok_valid: got %b expected 1", vld_e); end
        if (data_e !== 8'h03) begin errors++; $display("FAIL par_ok_data: got %h expected 03", data_e); end
        if (pe_e !== 1'b0)    begin errors++; $display("FAIL par_ok_flag: got %b expected 0", pe_e); end
        pulse_ack(1'b1);
    endtask

    task automatic test_glitch;
        rx_n = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy_n !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy_n); end
        repeat (14) @(negedge clk);
        rx_n = 1'b1;
        repeat (40) @(negedge clk);
        checks += 2;
        if (busy_n !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy_n); end
        if (vld_n !== 1'b0)  begin errors++; $display("FAIL glitch_valid: got %b expected 0", vld_n); end
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        checks += 3;
        if (vld_n !== 1'b1)   begin errors++; $display("FAIL b2b_valid: got %b expected 1", vld_n); end
        if (data_n !== 8'h11) begin errors++; $display("FAIL b2b_data_held: got %h expected 11", data_n); end
        if (ovr_n !== 1'b1)   begin errors++; $display("FAIL b2b_overrun_set: got %b expected 1", ovr_n); end
        pulse_ack(1'b0);
        checks += 2;
        if (ovr_n !== 1'b0)   begin errors++; $display("FAIL b2b_overrun_clr: got %b expected 0", ovr_n); end
        if (vld_n !== 1'b0)   begin errors++; $display("FAIL b2b_valid_clr: got %b expected 0", vld_n); end
    endtask

    task automatic test_frame_err;
        send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b0);
        checks += 3;
        if (vld_n !== 1'b1)   begin errors++; $display("FAIL ferr_valid: got %b expected 1", vld_n); end
        if (fe_n !== 1'b1)    begin errors++; $display("FAIL ferr_flag: got %b expected 1", fe_n); end
        if (data_n !== 8'h7E) begin errors++; $display("FAIL ferr_data: got %h expected 7e", data_n); end
        rx_n = 1'b1;
        repeat (2*BIT_CLKS) @(negedge clk);
        pulse_ack(1'b0);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        checks += 4;
        if (vld_n !== 1'b1)   begin errors++; $display("FAIL recover_valid: got %b expected 1", vld_n); end
        if (data_n !== 8'h55) begin errors++; $display("FAIL recover_data: got %h expected 55", data_n); end
        if (fe_n !== 1'b0)    begin errors++; $display("FAIL recover_frame_err: got %b expected 0", fe_n); end
        if (pe_n !== 1'b0)    begin errors++; $display("FAIL recover_parity_err: got %b expected 0", pe_n); end
    endtask

    task automatic test_reset_mid;
        // 0x55 from the previous scenario is still held, so reset must clear it
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks += 4;
        if (vld_n !== 1'b0)   begin errors++; $display("FAIL rmid_valid: got %b expected 0", vld_n); end
        if (data_n !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", data_n); end
        if (busy_n !== 1'b0)  begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy_n); end
        if (ovr_n !== 1'b0)   begin errors++; $display("FAIL rmid_overrun: got %b expected 0", ovr_n); end
        rst = 1'b1;
        for (int i = 0; i < 7; i++) drive_bit(1'b0, 1'b1);
        checks += 2;
        if (vld_n !== 1'b0)   begin errors++; $display("FAIL rmid_no_output: got %b expected 0", vld_n); end
        if (busy_n !== 1'b0)  begin errors++; $display("FAIL rmid_idle: got %b expected 0", busy_n); end
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        checks += 3;
        if (vld_n !== 1'b1)   begin errors++; $display("FAIL rmid_next_valid: got %b expected 1", vld_n); end
        if (data_n !== 8'h5A) begin errors++; $display("FAIL rmid_next_data: got %h expected 5a", data_n); end
        if (fe_n !== 1'b0)    begin errors++; $display("FAIL rmid_next_ferr: got %b expected 0", fe_n); end
    endtask

    initial begin
        rst   = 1'b0;
        rx_n  = 1'b1;
        rx_e  = 1'b1;
        ack_n = 1'b0;
        ack_e = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        repeat (8) @(negedge clk);
        test_basic();
        test_parity();
        test_glitch();
        test_back_to_back();
        test_frame_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
